// File: rtl/iter_shifter.sv
// Multi-cycle shifter: shifts a latched operand STEP bits per cycle (SLL/SRL/SRA).
// Optional macro ITER_SHIFTER_ROR_EN makes Shiftop 10 a rotate-right instead of a zero result.
module iter_shifter #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned SHAMT_W    = 5,
  parameter int unsigned STEP       = 1
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] A,
  input  logic [DATA_WIDTH-1:0] B,
  input  logic [1:0]            Shiftop,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] Result,
  output logic                  busy
);

  // One extra bit so that STEP == DATA_WIDTH is representable
  localparam int unsigned CNT_W = SHAMT_W + 1;

  localparam logic [1:0] OP_SLL = 2'b00;
  localparam logic [1:0] OP_SRL = 2'b01;
  localparam logic [1:0] OP_ROR = 2'b10;
  localparam logic [1:0] OP_SRA = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  state_t                state;
  logic [DATA_WIDTH-1:0] data;
  logic [SHAMT_W-1:0]    rem;
  logic [1:0]            op;

  logic [SHAMT_W-1:0]    amt;
  logic [DATA_WIDTH-1:0] load_data;
  logic [CNT_W-1:0]      step_amt;
  logic [SHAMT_W-1:0]    rem_next;
  logic [DATA_WIDTH-1:0] shifted;
  logic                  unused_b_hi;

  assign amt         = B[SHAMT_W-1:0];
  assign unused_b_hi = ^B[DATA_WIDTH-1:SHAMT_W];

  // Value latched at accept; the reserved op without rotate support collapses to zero
  always_comb begin
    load_data = A;
`ifndef ITER_SHIFTER_ROR_EN
    if (Shiftop == OP_ROR) begin
      load_data = '0;
    end
`endif
  end

  // Bits moved this cycle: min(rem, STEP)
  always_comb begin
    step_amt = CNT_W'(STEP);
    if ({1'b0, rem} < CNT_W'(STEP)) begin
      step_amt = {1'b0, rem};
    end
    rem_next = rem - SHAMT_W'(step_amt);
  end

  // Single-step shift; SRA keeps the sign since the MSB never changes under >>>
  always_comb begin
    shifted = '0;
    case (op)
      OP_SLL:  shifted = data << step_amt;
      OP_SRL:  shifted = data >> step_amt;
      OP_SRA:  shifted = $unsigned($signed(data) >>> step_amt);
`ifdef ITER_SHIFTER_ROR_EN
      OP_ROR:  shifted = (data >> step_amt) | (data << (CNT_W'(DATA_WIDTH) - step_amt));
`endif
      default: shifted = '0;
    endcase
  end

  // Control FSM with registered handshake outputs
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state     <= ST_IDLE;
      data      <= '0;
      rem       <= '0;
      op        <= '0;
      Result    <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (in_valid) begin
            op       <= Shiftop;
            rem      <= amt;
            data     <= load_data;
            in_ready <= 1'b0;
            busy     <= 1'b1;
            if (amt == '0) begin
              Result    <= load_data;
              out_valid <= 1'b1;
              state     <= ST_DONE;
            end else begin
              state <= ST_SHIFT;
            end
          end
        end
        ST_SHIFT: begin
          data <= shifted;
          rem  <= rem_next;
          if (rem_next == '0) begin
            Result    <= shifted;
            out_valid <= 1'b1;
            state     <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            busy      <= 1'b0;
            state     <= ST_IDLE;
          end
        end
        default: begin
          state     <= ST_IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_iter_shifter.sv
// Self-checking bench for iter_shifter: STEP=1 and STEP=4 instances, vector table,
// hand-written handshake/reset sequences and random ops against an arithmetic model.
module tb_iter_shifter;

  logic        clk = 1'b0;
  logic        resetn;
  logic [31:0] A, B;
  logic [1:0]  Shiftop;
  logic        in_valid1, in_ready1, out_valid1, out_ready1, busy1;
  logic        in_valid4, in_ready4, out_valid4, out_ready4, busy4;
  logic [31:0] result1, result4;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  iter_shifter #(.DATA_WIDTH(32), .SHAMT_W(5), .STEP(1)) dut (
    .clk(clk), .resetn(resetn), .in_valid(in_valid1), .in_ready(in_ready1),
    .A(A), .B(B), .Shiftop(Shiftop), .out_valid(out_valid1), .out_ready(out_ready1),
    .Result(result1), .busy(busy1)
  );

  iter_shifter #(.DATA_WIDTH(32), .SHAMT_W(5), .STEP(4)) dut4 (
    .clk(clk), .resetn(resetn), .in_valid(in_valid4), .in_ready(in_ready4),
    .A(A), .B(B), .Shiftop(Shiftop), .out_valid(out_valid4), .out_ready(out_ready4),
    .Result(result4), .busy(busy4)
  );

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [1:0]  op;
    bit          use4;
    logic [31:0] exp_res;
    int          exp_lat;
  } vec_t;

  vec_t vecs[11];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: plain arithmetic on the full shift amount
  function automatic logic [31:0] model_res(input logic [31:0] a, input logic [31:0] b,
                                            input logic [1:0] op);
    int unsigned amt;
    logic signed [31:0] sa;
    logic [63:0] dbl;
    amt = b % 32;
    sa  = a;
    dbl = {a, a} >> amt;
    case (op)
      2'b00:   return a << amt;
      2'b01:   return a >> amt;
      2'b11:   return sa >>> amt;
`ifdef ITER_SHIFTER_ROR_EN
      default: return dbl[31:0];
`else
      default: return 32'h0;
`endif
    endcase
  endfunction

  function automatic int model_lat(input logic [31:0] b, input int step);
    int amt;
    amt = int'(b % 32);
    return 1 + (amt + step - 1) / step;
  endfunction

  function automatic logic cur_ov(input bit u);
    return u ? out_valid4 : out_valid1;
  endfunction

  function automatic logic [31:0] cur_res(input bit u);
    return u ? result4 : result1;
  endfunction

  // Issue one request, measure edges from accept to out_valid, then drain it
  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic [1:0] op,
                        input bit use4, output logic [31:0] res, output int lat);
    @(negedge clk);
    A = a; B = b; Shiftop = op;
    if (use4) in_valid4 = 1'b1; else in_valid1 = 1'b1;
    @(posedge clk); #1;
    in_valid1 = 1'b0; in_valid4 = 1'b0;
    A = $urandom; B = $urandom; Shiftop = 2'($urandom);
    chk("busy_after_accept", 32'(use4 ? busy4 : busy1), 32'd1);
    chk("in_ready_after_accept", 32'(use4 ? in_ready4 : in_ready1), 32'd0);
    lat = 1;
    while (!cur_ov(use4) && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    if (lat >= 100) chk("timeout_out_valid", 32'(cur_ov(use4)), 32'd1);
    res = cur_res(use4);
    if (use4) out_ready4 = 1'b1; else out_ready1 = 1'b1;
    @(posedge clk); #1;
    out_ready1 = 1'b0; out_ready4 = 1'b0;
    chk("in_ready_after_drain", 32'(use4 ? in_ready4 : in_ready1), 32'd1);
    chk("out_valid_after_drain", 32'(cur_ov(use4)), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] res;
    int lat;
    logic [31:0] ra, rb;
    logic [1:0]  rop;
    bit          r4;

    vecs[0]  = '{32'h00000001, 32'd31,       2'b00, 1'b0, 32'h80000000, 32};
    vecs[1]  = '{32'h00000001, 32'd31,       2'b00, 1'b1, 32'h80000000, 9};
    vecs[2]  = '{32'h80000000, 32'd4,        2'b11, 1'b0, 32'hF8000000, 5};
    vecs[3]  = '{32'hF0000000, 32'h25,       2'b01, 1'b0, 32'h07800000, 6};
    vecs[4]  = '{32'h12345678, 32'd0,        2'b00, 1'b0, 32'h12345678, 1};
    vecs[5]  = '{32'h000000FF, 32'd4,        2'b01, 1'b0, 32'h0000000F, 5};
`ifdef ITER_SHIFTER_ROR_EN
    vecs[6]  = '{32'h00000001, 32'd1,        2'b10, 1'b0, 32'h80000000, 2};
`else
    vecs[6]  = '{32'h00000001, 32'd1,        2'b10, 1'b0, 32'h00000000, 2};
`endif
    vecs[7]  = '{32'h7FFFFFFF, 32'd31,       2'b11, 1'b0, 32'h00000000, 32};
    vecs[8]  = '{32'h80000001, 32'd63,       2'b11, 1'b0, 32'hFFFFFFFF, 32};
    vecs[9]  = '{32'h80000000, 32'd4,        2'b11, 1'b1, 32'hF8000000, 2};
    vecs[10] = '{32'hF0F0F0F0, 32'd6,        2'b01, 1'b1, 32'h03C3C3C3, 3};

    resetn = 1'b0; in_valid1 = 1'b0; in_valid4 = 1'b0;
    out_ready1 = 1'b0; out_ready4 = 1'b0;
    A = 32'h0; B = 32'h0; Shiftop = 2'b00;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_in_ready", 32'(in_ready1), 32'd1);
    chk("reset_out_valid", 32'(out_valid1), 32'd0);
    chk("reset_busy", 32'(busy1), 32'd0);
    chk("reset_result", result1, 32'h0);
    chk("reset_result_s4", result4, 32'h0);
    resetn = 1'b1;

    for (int i = 0; i < 11; i++) begin
      run_op(vecs[i].a, vecs[i].b, vecs[i].op, vecs[i].use4, res, lat);
      chk($sformatf("vec%0d_result", i), res, vecs[i].exp_res);
      chk($sformatf("vec%0d_latency", i), 32'(lat), 32'(vecs[i].exp_lat));
    end

    // Zero shift, then hold backpressure while the requester misbehaves
    @(negedge clk);
    A = 32'h12345678; B = 32'h0; Shiftop = 2'b00; in_valid1 = 1'b1;
    @(posedge clk); #1;
    in_valid1 = 1'b0;
    chk("bp_out_valid_t1", 32'(out_valid1), 32'd1);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      in_valid1 = ~in_valid1; A = $urandom; B = $urandom;
      @(posedge clk); #1;
      chk("bp_result_stable", result1, 32'h12345678);
      chk("bp_in_ready_low", 32'(in_ready1), 32'd0);
      chk("bp_out_valid_held", 32'(out_valid1), 32'd1);
    end
    in_valid1 = 1'b0;
    out_ready1 = 1'b1;
    @(posedge clk); #1;
    out_ready1 = 1'b0;
    chk("bp_idle_in_ready", 32'(in_ready1), 32'd1);
    chk("bp_idle_out_valid", 32'(out_valid1), 32'd0);
    run_op(32'hA5A5A5A5, 32'd8, 2'b01, 1'b0, res, lat);
    chk("bp_next_result", res, 32'h00A5A5A5);

    // Reset in the middle of a 20-bit shift discards it
    @(negedge clk);
    A = 32'h00000003; B = 32'd20; Shiftop = 2'b00; in_valid1 = 1'b1;
    @(posedge clk); #1;
    in_valid1 = 1'b0;
    for (int c = 0; c < 4; c++) begin
      chk("rst_mid_no_out_valid", 32'(out_valid1), 32'd0);
      @(posedge clk); #1;
    end
    resetn = 1'b0;
    @(posedge clk); #1;
    resetn = 1'b1;
    chk("rst_mid_in_ready", 32'(in_ready1), 32'd1);
    chk("rst_mid_out_valid", 32'(out_valid1), 32'd0);
    chk("rst_mid_busy", 32'(busy1), 32'd0);
    chk("rst_mid_result", result1, 32'h0);
    run_op(32'h000000FF, 32'd4, 2'b01, 1'b0, res, lat);
    chk("rst_after_result", res, 32'h0000000F);
    chk("rst_after_latency", 32'(lat), 32'd5);

    // Random ops on both instances against the arithmetic model
    for (int i = 0; i < 40; i++) begin
      ra  = $urandom;
      rb  = $urandom;
      rop = 2'($urandom_range(0, 3));
      r4  = bit'($urandom_range(0, 1));
      run_op(ra, rb, rop, r4, res, lat);
      chk($sformatf("rand%0d_result", i), res, model_res(ra, rb, rop));
      chk($sformatf("rand%0d_latency", i), 32'(lat), 32'(model_lat(rb, r4 ? 4 : 1)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
